// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding-select logic: select encodings and
// the per-stage producer tracking slot.
// Latency: n/a (types only). Backpressure: n/a.
package fwd_pkg;

  // Register-address width the slot type is built for.
  localparam int FWD_REG_AW = 5;

  // EX operand mux select encodings.
  localparam logic [1:0] FWD_RF    = 2'b00;  // register file read data
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result
  localparam logic [1:0] FWD_PWB   = 2'b11;  // post-WB latch

  // One in-flight instruction as seen by the forwarding logic.
  typedef struct packed {
    logic                  valid;
    logic [FWD_REG_AW-1:0] dest;
    logic                  is_load;
    logic                  reg_write;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // True when the slot will write 'addr' back; r0 is never a real producer.
  function automatic logic slot_writes(slot_t s, logic [FWD_REG_AW-1:0] addr);
    return s.valid && s.reg_write && (s.dest == addr) && (addr != '0);
  endfunction

endpackage

// File: rtl/fwd_select_unit_if.sv
// ID-stage instruction info, pipeline control and forwarding outputs of the
// forwarding-select unit. master = pipeline/ID side, slave = the unit.
// Latency: n/a (wires only). Backpressure: ld_use_stall, pipe_hold.
interface fwd_select_unit_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_write;
  logic              id_is_load;
  logic              pipe_hold;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic              ld_use_stall;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_reg_write, id_is_load, pipe_hold, flush,
    input  fwd_a_sel, fwd_b_sel, ld_use_stall
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_reg_write, id_is_load, pipe_hold, flush,
    output fwd_a_sel, fwd_b_sel, ld_use_stall
  );

endinterface

// File: rtl/fwd_match.sv
// Youngest-first compare of one source address against EX, MEM and WB producers.
// Latency: combinational. Backpressure: none.
// Ports: src/use_src = operand address and use flag; ex/mem/wb_slot = producers; sel = mux select.
module fwd_match
  import fwd_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic [FWD_REG_AW-1:0] src,
  input  logic                  use_src,
  input  slot_t                 ex_slot,
  input  slot_t                 mem_slot,
  input  slot_t                 wb_slot,
  output logic [1:0]            sel
);

  // The producer kind does not matter here; load-use is handled by the stall.
  logic unused_is_load;
  assign unused_is_load = ex_slot.is_load ^ mem_slot.is_load ^ wb_slot.is_load;

  // Slots are sampled one edge before the consumer enters EX, so the current
  // EX producer will sit in MEM (EX/MEM result), MEM in WB, WB in post-WB.
  always_comb begin
    sel = FWD_RF;
    if (use_src) begin
      if (slot_writes(ex_slot, src)) begin
        sel = FWD_EXMEM;
      end else if (slot_writes(mem_slot, src)) begin
        sel = FWD_MEMWB;
      end else if (WB_BYPASS && slot_writes(wb_slot, src)) begin
        sel = FWD_PWB;
      end
    end
  end

endmodule

// File: rtl/fwd_select_unit.sv
// Forwarding-select generator: tracks EX/MEM/WB/PWB producers, registers the
// EX operand selects and raises the load-use stall.
// Latency: selects registered (valid for the instruction's whole EX residency);
// ld_use_stall combinational. Backpressure: pipe_hold freezes everything.
// Ports: clk, rst_n (sync active-low), bus (ID info, hold/flush in; selects/stall out).
module fwd_select_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW    = FWD_REG_AW,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_select_unit_if.slave bus
);

  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;

  assign id_rs = bus.id_rs;
  assign id_rt = bus.id_rt;
  assign id_rd = bus.id_rd;

  slot_t ex_q, ex_d;
  slot_t mem_q, mem_d;
  slot_t wb_q, wb_d;
  slot_t pwb_q, pwb_d;
  logic [1:0] fwd_a_sel_q, fwd_a_sel_d;
  logic [1:0] fwd_b_sel_q, fwd_b_sel_d;

  logic [1:0] a_match;
  logic [1:0] b_match;
  logic       stall;
  slot_t      id_slot;

  // The post-WB slot is kept for pipeline visibility only; the forwarding
  // decision reads the WB slot one edge earlier.
  logic pwb_unused;
  assign pwb_unused = ^pwb_q;

  fwd_match #(.WB_BYPASS(WB_BYPASS)) u_match_a (
    .src      (id_rs),
    .use_src  (bus.id_use_rs),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (a_match)
  );

  fwd_match #(.WB_BYPASS(WB_BYPASS)) u_match_b (
    .src      (id_rt),
    .use_src  (bus.id_use_rt),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (b_match)
  );

  always_comb begin
    // A load result is not ready at the end of EX, so a dependent consumer
    // waits one cycle and then picks it up from MEM/WB. Flush kills the
    // consumer, which makes the stall pointless.
    stall = bus.id_valid && ex_q.valid && ex_q.is_load && (ex_q.dest != '0) &&
            ((bus.id_use_rs && (id_rs == ex_q.dest)) ||
             (bus.id_use_rt && (id_rt == ex_q.dest))) &&
            !bus.flush;

    id_slot           = SLOT_BUBBLE;
    id_slot.valid     = 1'b1;
    id_slot.dest      = id_rd;
    id_slot.is_load   = bus.id_is_load;
    id_slot.reg_write = bus.id_reg_write;

    ex_d        = ex_q;
    mem_d       = mem_q;
    wb_d        = wb_q;
    pwb_d       = pwb_q;
    fwd_a_sel_d = fwd_a_sel_q;
    fwd_b_sel_d = fwd_b_sel_q;

    if (!bus.pipe_hold) begin
      pwb_d = wb_q;
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bus.id_valid && !bus.flush && !stall) begin
        ex_d        = id_slot;
        fwd_a_sel_d = a_match;
        fwd_b_sel_d = b_match;
      end else begin
        ex_d        = SLOT_BUBBLE;
        fwd_a_sel_d = FWD_RF;
        fwd_b_sel_d = FWD_RF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q        <= SLOT_BUBBLE;
      mem_q       <= SLOT_BUBBLE;
      wb_q        <= SLOT_BUBBLE;
      pwb_q       <= SLOT_BUBBLE;
      fwd_a_sel_q <= FWD_RF;
      fwd_b_sel_q <= FWD_RF;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      pwb_q       <= pwb_d;
      fwd_a_sel_q <= fwd_a_sel_d;
      fwd_b_sel_q <= fwd_b_sel_d;
    end
  end

  assign bus.fwd_a_sel    = fwd_a_sel_q;
  assign bus.fwd_b_sel    = fwd_b_sel_q;
  assign bus.ld_use_stall = stall;

endmodule

// File: tb/tb_fwd_select_unit.sv
// Bench for fwd_select_unit: directed hazard sequences plus random instruction
// streams, all compared against an instruction-level pipeline model.
// Latency/backpressure: drives hold/flush and honours ld_use_stall like IF/ID.
module tb_fwd_select_unit;

  localparam int AW  = 5;
  localparam bit WBB = 1'b1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fwd_select_unit_if #(.REG_AW(AW)) bus ();

  fwd_select_unit #(.REG_AW(AW), .WB_BYPASS(WBB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit v; int rs; int rt; bit urs; bit urt; int rd; bit wr; bit ld;
  } ins_t;

  // Instruction-level model: what is in EX, MEM, WB (index 0 = EX).
  typedef struct { bit v; int d; bit wr; bit ld; } mslot_t;
  mslot_t pipe[$];
  int exp_a, exp_b;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic ins_t mk(int rd, int rs, int rt, bit wr, bit ld, bit urs, bit urt);
    ins_t i;
    i.v = 1'b1; i.rd = rd; i.rs = rs; i.rt = rt;
    i.wr = wr; i.ld = ld; i.urs = urs; i.urt = urt;
    return i;
  endfunction

  function automatic ins_t alu(int rd, int rs, int rt);
    return mk(rd, rs, rt, 1'b1, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic ins_t lw(int rd, int rs);
    return mk(rd, rs, 0, 1'b1, 1'b1, 1'b1, 1'b0);
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic ins_t rnd_ins();
    ins_t i;
    i.v   = ($urandom_range(0, 7) != 0);
    i.rs  = $urandom_range(0, 7);
    i.rt  = $urandom_range(0, 7);
    i.rd  = $urandom_range(0, 7);
    i.urs = $urandom_range(0, 3) != 0;
    i.urt = $urandom_range(0, 3) != 0;
    i.wr  = $urandom_range(0, 4) != 0;
    i.ld  = $urandom_range(0, 2) == 0;
    return i;
  endfunction

  // The nearest older instruction that writes the register supplies it:
  // one stage ahead -> EX/MEM (1), two -> MEM/WB (2), three -> post-WB (3).
  function automatic int sel_for(int addr, bit used);
    if (!used || addr == 0) return 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2 && !WBB) return 0;
      if (pipe[k].v && pipe[k].wr && pipe[k].d == addr) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit model_stall(ins_t i, bit fl);
    if (fl || !i.v) return 1'b0;
    if (!(pipe[0].v && pipe[0].ld && pipe[0].d != 0)) return 1'b0;
    return (i.urs && i.rs == pipe[0].d) || (i.urt && i.rt == pipe[0].d);
  endfunction

  function automatic void model_reset();
    mslot_t b;
    b = '{v: 1'b0, d: 0, wr: 1'b0, ld: 1'b0};
    pipe.delete();
    for (int k = 0; k < 3; k++) pipe.push_back(b);
    exp_a = 0;
    exp_b = 0;
  endfunction

  task automatic drive(input ins_t i, input bit hold, input bit fl);
    bus.id_valid     = i.v;
    bus.id_rs        = AW'(i.rs);
    bus.id_rt        = AW'(i.rt);
    bus.id_use_rs    = i.urs;
    bus.id_use_rt    = i.urt;
    bus.id_rd        = AW'(i.rd);
    bus.id_reg_write = i.wr;
    bus.id_is_load   = i.ld;
    bus.pipe_hold    = hold;
    bus.flush        = fl;
  endtask

  // Called just after a rising edge; presents ID, checks, advances one cycle.
  task automatic step(input ins_t i, input bit hold, input bit fl, output bit stalled);
    bit es;
    int na, nb;
    mslot_t ns;
    drive(i, hold, fl);
    #1;
    es = model_stall(i, fl);
    check_eq("ld_use_stall", int'(bus.ld_use_stall), int'(es));
    check_eq("fwd_a_sel", int'(bus.fwd_a_sel), exp_a);
    check_eq("fwd_b_sel", int'(bus.fwd_b_sel), exp_b);
    stalled = es;
    @(posedge clk);
    #1;
    if (!hold) begin
      if (i.v && !fl && !es) begin
        ns = '{v: 1'b1, d: i.rd, wr: i.wr, ld: i.ld};
        na = sel_for(i.rs, i.urs);
        nb = sel_for(i.rt, i.urt);
      end else begin
        ns = '{v: 1'b0, d: 0, wr: 1'b0, ld: 1'b0};
        na = 0;
        nb = 0;
      end
      pipe.push_front(ns);
      void'(pipe.pop_back());
      exp_a = na;
      exp_b = nb;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(nop(), 1'b0, 1'b0);
    bus.id_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check_eq("rst_sel_a", int'(bus.fwd_a_sel), 0);
    check_eq("rst_sel_b", int'(bus.fwd_b_sel), 0);
    check_eq("rst_stall", int'(bus.ld_use_stall), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit s, s1, s2;
    ins_t cur;
    bit hold, fl;

    do_reset();

    // Independent add.
    step(alu(3, 1, 2), 1'b0, 1'b0, s);
    check_eq("add_sel_a", int'(bus.fwd_a_sel), 0);
    check_eq("add_sel_b", int'(bus.fwd_b_sel), 0);
    check_eq("add_stall", int'(s), 0);

    // Back-to-back dependency on both operands.
    step(alu(5, 1, 2), 1'b0, 1'b0, s);
    step(alu(6, 5, 5), 1'b0, 1'b0, s);
    check_eq("b2b_sel_a", int'(bus.fwd_a_sel), 1);
    check_eq("b2b_sel_b", int'(bus.fwd_b_sel), 1);

    // One and two instructions apart.
    step(alu(5, 1, 2), 1'b0, 1'b0, s);
    step(nop(), 1'b0, 1'b0, s);
    step(alu(7, 1, 5), 1'b0, 1'b0, s);
    check_eq("gap1_sel_b", int'(bus.fwd_b_sel), 2);
    step(alu(5, 1, 2), 1'b0, 1'b0, s);
    step(nop(), 1'b0, 1'b0, s);
    step(nop(), 1'b0, 1'b0, s);
    step(alu(7, 1, 5), 1'b0, 1'b0, s);
    check_eq("gap2_sel_b", int'(bus.fwd_b_sel), WBB ? 3 : 0);

    // Load-use: one stall cycle, bubble in EX, then MEM/WB forward.
    step(lw(4, 1), 1'b0, 1'b0, s);
    step(alu(8, 4, 1), 1'b0, 1'b0, s1);
    check_eq("lu_stall_1st", int'(s1), 1);
    check_eq("lu_bubble_a", int'(bus.fwd_a_sel), 0);
    check_eq("lu_bubble_b", int'(bus.fwd_b_sel), 0);
    step(alu(8, 4, 1), 1'b0, 1'b0, s2);
    check_eq("lu_stall_2nd", int'(s2), 0);
    check_eq("lu_sel_a", int'(bus.fwd_a_sel), 2);
    check_eq("lu_sel_b", int'(bus.fwd_b_sel), 0);

    // Youngest producer wins; r0 is never forwarded.
    step(alu(9, 1, 2), 1'b0, 1'b0, s);
    step(alu(9, 3, 4), 1'b0, 1'b0, s);
    step(alu(10, 9, 9), 1'b0, 1'b0, s);
    check_eq("young_sel_a", int'(bus.fwd_a_sel), 1);
    check_eq("young_sel_b", int'(bus.fwd_b_sel), 1);
    step(alu(0, 1, 2), 1'b0, 1'b0, s);
    step(alu(11, 0, 0), 1'b0, 1'b0, s);
    check_eq("r0_sel_a", int'(bus.fwd_a_sel), 0);
    check_eq("r0_sel_b", int'(bus.fwd_b_sel), 0);

    // Freeze for three cycles with a live forward in EX.
    step(alu(12, 1, 2), 1'b0, 1'b0, s);
    step(alu(13, 12, 12), 1'b0, 1'b0, s);
    for (int k = 0; k < 3; k++) begin
      step(alu(14, 13, 1), 1'b1, 1'b0, s);
      check_eq("hold_sel_a", int'(bus.fwd_a_sel), 1);
      check_eq("hold_sel_b", int'(bus.fwd_b_sel), 1);
    end
    step(alu(14, 13, 1), 1'b0, 1'b0, s);
    check_eq("unhold_sel_a", int'(bus.fwd_a_sel), 1);
    check_eq("unhold_sel_b", int'(bus.fwd_b_sel), 0);

    // Flush during a load-use hit.
    step(lw(4, 1), 1'b0, 1'b0, s);
    step(alu(8, 4, 4), 1'b0, 1'b1, s);
    check_eq("flush_stall", int'(s), 0);
    check_eq("flush_sel_a", int'(bus.fwd_a_sel), 0);
    check_eq("flush_sel_b", int'(bus.fwd_b_sel), 0);

    // Random streams; ID re-presents the same instruction while held/stalled.
    cur = rnd_ins();
    for (int n = 0; n < 600; n++) begin
      hold = ($urandom_range(0, 9) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      step(cur, hold, fl, s);
      if (!(hold || (s && !fl))) cur = rnd_ins();
    end

    // Reset with a load live in EX.
    step(lw(4, 1), 1'b0, 1'b0, s);
    do_reset();
    step(alu(8, 4, 4), 1'b0, 1'b0, s);
    check_eq("post_rst_stall", int'(s), 0);
    check_eq("post_rst_sel_a", int'(bus.fwd_a_sel), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
